// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array, its feeders and its result collector.
package systolic_pkg;

  localparam int DIN_WIDTH_DEF = 8;
  localparam int RES_W         = 2 * DIN_WIDTH_DEF;
  localparam int N_DEF         = 2;
  localparam int IDX_W_DEF     = $clog2(N_DEF);
  localparam int DROP_CNT_W    = 8;

  typedef logic [RES_W-1:0]     result_t;
  typedef logic [IDX_W_DEF-1:0] row_idx_t;

endpackage

// File: rtl/systolic_result_collector_fifo.sv
// Register FIFO holding DEPTH complete result vectors of N elements each.
// The head entry is presented combinationally from the read pointer.
module result_vec_fifo #(
  parameter int RES_W = 16,
  parameter int N     = 2,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [RES_W-1:0] vec_i [N],
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [RES_W-1:0] head_o [N]
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [RES_W-1:0] mem_q [DEPTH][N];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;

  // Occupancy next-state: simultaneous push and pop leave it unchanged
  always_comb begin
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage, pointers and occupancy; pointers wrap naturally at DEPTH
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int d = 0; d < DEPTH; d++) begin
        for (int e = 0; e < N; e++) begin
          mem_q[d][e] <= '0;
        end
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        for (int e = 0; e < N; e++) begin
          mem_q[wr_ptr_q][e] <= vec_i[e];
        end
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop_i) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_d;
    end
  end

  // Head entry and status flags
  always_comb begin
    for (int e = 0; e < N; e++) begin
      head_o[e] = mem_q[rd_ptr_q][e];
    end
    full_o  = (count_q == CNT_W'(DEPTH));
    empty_o = (count_q == '0);
  end

endmodule

// File: rtl/systolic_result_collector.sv
// Collects the serialized result stream of the systolic array, reassembles
// N-element vectors and buffers them behind a valid/ready output. The array
// cannot be stalled, so a vector completing into a full buffer is dropped
// and counted.
module systolic_result_collector
  import systolic_pkg::*;
#(
  parameter int DIN_WIDTH = 8,
  parameter int N         = 2,
  parameter int DEPTH     = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [2*DIN_WIDTH-1:0]      s_data,
  input  logic                        s_valid,
  input  logic [$clog2(N)-1:0]        s_idx,
  output logic [2*DIN_WIDTH-1:0]      m_data [N],
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic                        seq_err,
  output logic                        overflow,
  output logic [DROP_CNT_W-1:0]       drop_cnt
);

  localparam int RW    = 2 * DIN_WIDTH;
  localparam int IDX_W = $clog2(N);

  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [RW-1:0]         asm_q [N];
  logic [RW-1:0]         vec_in [N];
  logic [IDX_W-1:0]      exp_idx_q, exp_idx_d;
  logic                  seq_err_q, overflow_q;
  logic [DROP_CNT_W-1:0] drop_cnt_q;
  logic                  in_order, last_beat, push_req, drop, push_ok, pop;
  logic                  fifo_full, fifo_empty;

  // Beat classification, expected-index next state and push/drop decision
  always_comb begin
    in_order  = s_valid && (s_idx == exp_idx_q);
    last_beat = (exp_idx_q == IDX_W'(N - 1));
    push_req  = in_order && last_beat;
    for (int e = 0; e < N; e++) begin
      vec_in[e] = asm_q[e];
    end
    vec_in[N-1] = s_data;
    exp_idx_d = exp_idx_q;
    if (s_valid) begin
      if (in_order) begin
        exp_idx_d = last_beat ? '0 : exp_idx_q + 1'b1;
      end else begin
        // An out-of-order row 0 starts a fresh vector; anything else resyncs to 0
        exp_idx_d = (s_idx == '0) ? IDX_W'(1) : '0;
      end
    end
    pop     = !fifo_empty && m_ready;
    drop    = push_req && fifo_full && !pop;
    push_ok = push_req && !drop;
  end

  // Assembly register: in-order beats and resync beats at row 0 are stored
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int e = 0; e < N; e++) begin
        asm_q[e] <= '0;
      end
    end else if (s_valid && (in_order || s_idx == '0)) begin
      asm_q[s_idx] <= s_data;
    end
  end

  // Sequence state, registered error pulses and saturating drop counter
  always_ff @(posedge clk) begin
    if (rst) begin
      exp_idx_q  <= '0;
      seq_err_q  <= 1'b0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      exp_idx_q  <= exp_idx_d;
      seq_err_q  <= s_valid && !in_order;
      overflow_q <= drop;
      if (drop) begin
        drop_cnt_q <= sat_inc(drop_cnt_q);
      end
    end
  end

  result_vec_fifo #(
    .RES_W (RW),
    .N     (N),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_ok),
    .vec_i   (vec_in),
    .pop_i   (pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (m_data)
  );

  assign m_valid  = !fifo_empty;
  assign seq_err  = seq_err_q;
  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;

endmodule
